cpu_mem_ctrl: RTL and testbench
===============================

Name: cpu_mem_ctrl

Overview:
Parametrised memory/bus controller between the 6502 core and its memories. It decodes the CPU address into four regions: on-chip synchronous RAM, a small I/O register file, an external slow bus with a req/ack handshake and timeout, and unmapped space. It drives the CPU read data and RDY, inserting wait states only for external accesses. It replaces the fixed single-RAM hookup in the CPU top level.

Parameters:
AW, 16, CPU address width
DW, 8, data width
RAM_AW, 13, RAM address bits (2^RAM_AW words)
RAM_BASE, 16'h0000, RAM base, aligned to 2^RAM_AW
IO_AW, 4, I/O register address bits (2^IO_AW registers, min 2)
IO_BASE, 16'hD000, I/O base, aligned to 2^IO_AW
EXT_AW, 13, external window address bits
EXT_BASE, 16'hE000, external base, aligned to 2^EXT_AW
TIMEOUT, 16, max wait cycles per external access (>=1)
FILL, 8'hFF, read data for unmapped or timed-out reads

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ab  in  AW  CPU address
cpu_do  in  DW  CPU write data
we  in  1  CPU write enable
cpu_di  out  DW  read data to CPU
rdy  out  1  CPU ready; low = CPU holds ab/we/cpu_do
ext_req  out  1  external request, held until completion
ext_addr  out  EXT_AW  latched external address (ab low bits)
ext_wdata  out  DW  latched write data
ext_we  out  1  latched write enable
ext_ack  in  1  external completion strobe
ext_rdata  in  DW  external read data, valid with ext_ack
gpio_in  in  DW  asynchronous input port
gpio_out  out  DW  I/O register 0
bus_err  out  1  sticky timeout flag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Decode: region hit when (ab >> X_AW) == (X_BASE >> X_AW). Priority on overlap: IO > EXT > RAM > unmapped.
- States: IDLE, EXT_WAIT. rdy = (state == IDLE), registered.
- Accept: on any edge with state IDLE, the current ab/we/cpu_do form an access. While in EXT_WAIT, ab is ignored and no RAM or IO writes occur.
- RAM: on accept with we, mem[ab[RAM_AW-1:0]] <= cpu_do. Reads are registered: cpu_di is valid in the cycle after presentation. A read of a location on the same cycle it is written returns old data.
- IO registers:
  - Offset 0 gpio_out: R/W.
  - Offset 1: read-only gpio_in, passed through a 2-flop synchroniser.
  - Offset 2 status: bit0 = bus_err, other bits 0; writing 1 to bit0 clears it.
  - Offsets 3 and up: R/W scratch.
  - Read latency is 1 cycle, same as RAM.
- Read mux: cpu_di selected by the registered region select from the accepting edge. Unmapped region returns FILL. Unmapped writes are dropped.
- EXT access, accepted at end of cycle n:
  - Edge n: state goes to EXT_WAIT; ext_req=1; ext_addr/ext_wdata/ext_we latched; wait counter = 0.
  - rdy is low from cycle n+1.
  - Each EXT_WAIT cycle: if ext_ack=1, capture ext_rdata into the hold register, go IDLE, drop ext_req. Otherwise, if counter == TIMEOUT-1, hold <= FILL, bus_err <= 1, go IDLE. Otherwise counter++.
  - rdy is low for k cycles, where k = ack cycle offset (1..TIMEOUT). cpu_di = hold in the first cycle rdy is high again.
  - Ack and timeout on the same edge: ack wins, no error.
  - ext_ack while IDLE is ignored.
- bus_err: a timeout set and a status write-1-clear on the same edge resolve to set.
- Reset values: state IDLE, rdy=1, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, bus_err=0, gpio_out=0, scratch=0, region select=unmapped (cpu_di=FILL), hold=FILL, synchroniser=0. RAM contents are not cleared.
- Reset during EXT_WAIT: abort immediately; next cycle ext_req=0, rdy=1. Late ext_ack is ignored.
- Counter width: clog2(TIMEOUT)+1. It never wraps.

Test Plan:
- RAM: write 8'hA5 to 16'h0123 (we=1), then read 16'h0123 → cpu_di=8'hA5 one cycle later, rdy stays 1 throughout.
- IO: write 8'h3C to 16'hD000 → gpio_out=8'h3C. gpio_in=8'h81 held 3 cycles, read 16'hD001 → 8'h81. Read 16'hD002 after reset → 8'h00.
- EXT read: read 16'hE010, ext_ack=1 with ext_rdata=8'h5A in the 3rd wait cycle → ext_addr=13'h0010, ext_req high 3 cycles, rdy low exactly 3 cycles, cpu_di=8'h5A when rdy returns, bus_err=0.
- Timeout: EXT write 8'h77 to 16'hF000, no ack → rdy low exactly 16 cycles, ext_we=1 and ext_wdata=8'h77 throughout, then bus_err=1. Read 16'hD002 → 8'h01. Write 8'h01 to 16'hD002 → bus_err=0.
- Boundaries: read unmapped 16'hC000 → 8'hFF. Ack on cycle 16 (same as timeout) → data taken, bus_err=0. Write RAM during EXT_WAIT (ab changed) → RAM unchanged.
- Reset mid-EXT_WAIT (cycle 5): next cycle rdy=1, ext_req=0, gpio_out=0, bus_err=0. Later ext_ack pulse → no effect. RAM data written earlier is still readable.

Source files
------------

// File: rtl/cpu_mem_ctrl_if.sv
// CPU-side bus and external slow-bus signals of the memory controller.
// The master modport is the CPU plus external device, the slave modport is the controller.
interface cpu_mem_ctrl_if #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int EXT_AW = 13
);
    logic [AW-1:0]     ab;
    logic [DW-1:0]     cpu_do;
    logic              we;
    logic [DW-1:0]     cpu_di;
    logic              rdy;
    logic              ext_req;
    logic [EXT_AW-1:0] ext_addr;
    logic [DW-1:0]     ext_wdata;
    logic              ext_we;
    logic              ext_ack;
    logic [DW-1:0]     ext_rdata;

    modport master (
        output ab, cpu_do, we, ext_ack, ext_rdata,
        input  cpu_di, rdy, ext_req, ext_addr, ext_wdata, ext_we
    );

    modport slave (
        input  ab, cpu_do, we, ext_ack, ext_rdata,
        output cpu_di, rdy, ext_req, ext_addr, ext_wdata, ext_we
    );
endinterface

// File: rtl/cpu_mem_ctrl.sv
// 6502 memory/bus controller: on-chip RAM, I/O registers, external
// req/ack window with timeout, and unmapped fill.
module cpu_mem_ctrl #(
    parameter int              AW       = 16,
    parameter int              DW       = 8,
    parameter int              RAM_AW   = 13,
    parameter logic [AW-1:0]   RAM_BASE = 16'h0000,
    parameter int              IO_AW    = 4,
    parameter logic [AW-1:0]   IO_BASE  = 16'hD000,
    parameter int              EXT_AW   = 13,
    parameter logic [AW-1:0]   EXT_BASE = 16'hE000,
    parameter int              TIMEOUT  = 16,
    parameter logic [DW-1:0]   FILL     = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    cpu_mem_ctrl_if.slave       bus,
    input  logic [DW-1:0]       gpio_in,
    output logic [DW-1:0]       gpio_out,
    output logic                bus_err
);
    localparam int IO_N = 2 ** IO_AW;
    localparam int CW   = $clog2(TIMEOUT) + 1;

    typedef enum logic {S_IDLE, S_EXT} state_e;
    typedef enum logic [1:0] {R_UNM, R_RAM, R_IO, R_EXT} region_e;

    state_e            state_q, state_d;
    region_e           region, sel_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     hold_q, hold_d;
    logic              err_q, err_d, err_set, err_clr;
    logic [DW-1:0]     mem [2**RAM_AW];
    logic [DW-1:0]     ram_rd_q;
    logic [DW-1:0]     io_q [IO_N];
    logic [DW-1:0]     io_rd_q, io_rd_d;
    logic [DW-1:0]     sync1_q, sync2_q;
    logic [EXT_AW-1:0] ext_addr_q;
    logic [DW-1:0]     ext_wdata_q;
    logic              ext_we_q;
    logic              accept, wr;
    logic [IO_AW-1:0]  io_off;
    logic [RAM_AW-1:0] ram_idx;

    always_comb begin
        region = R_UNM;
        if ((bus.ab >> IO_AW) == (IO_BASE >> IO_AW))
            region = R_IO;
        else if ((bus.ab >> EXT_AW) == (EXT_BASE >> EXT_AW))
            region = R_EXT;
        else if ((bus.ab >> RAM_AW) == (RAM_BASE >> RAM_AW))
            region = R_RAM;
    end

    assign accept  = (state_q == S_IDLE) && !reset;
    assign wr      = accept && bus.we;
    assign io_off  = bus.ab[IO_AW-1:0];
    assign ram_idx = bus.ab[RAM_AW-1:0];

    // RAM has no reset; a same-edge read sees the old word
    always_ff @(posedge clk) begin
        if (wr && region == R_RAM)
            mem[ram_idx] <= bus.cpu_do;
        if (accept)
            ram_rd_q <= mem[ram_idx];
    end

    always_comb begin
        io_rd_d = io_q[io_off];
        if (io_off == IO_AW'(1))
            io_rd_d = sync2_q;
        else if (io_off == IO_AW'(2))
            io_rd_d = {{(DW-1){1'b0}}, err_q};
    end

    always_ff @(posedge clk) begin
        if (accept)
            io_rd_q <= io_rd_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        err_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (region == R_EXT) begin
                    state_d = S_EXT;
                    cnt_d   = '0;
                end
            end
            S_EXT: begin
                if (bus.ext_ack) begin
                    hold_d  = bus.ext_rdata;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    hold_d  = FILL;
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A timeout on the same edge as a clear leaves the flag set
    assign err_clr = wr && region == R_IO &&
                     io_off == IO_AW'(2) && bus.cpu_do[0];
    assign err_d   = err_set || (err_q && !err_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_q      <= FILL;
            err_q       <= 1'b0;
            sel_q       <= R_UNM;
            sync1_q     <= '0;
            sync2_q     <= '0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_we_q    <= 1'b0;
            for (int i = 0; i < IO_N; i++)
                io_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            if (accept)
                sel_q <= region;
            if (accept && region == R_EXT) begin
                ext_addr_q  <= bus.ab[EXT_AW-1:0];
                ext_wdata_q <= bus.cpu_do;
                ext_we_q    <= bus.we;
            end
            if (wr && region == R_IO &&
                io_off != IO_AW'(1) && io_off != IO_AW'(2))
                io_q[io_off] <= bus.cpu_do;
        end
    end

    always_comb begin
        bus.cpu_di = FILL;
        unique case (sel_q)
            R_RAM:   bus.cpu_di = ram_rd_q;
            R_IO:    bus.cpu_di = io_rd_q;
            R_EXT:   bus.cpu_di = hold_q;
            default: bus.cpu_di = FILL;
        endcase
    end

    assign bus.rdy       = (state_q == S_IDLE);
    assign bus.ext_req   = (state_q == S_EXT);
    assign bus.ext_addr  = ext_addr_q;
    assign bus.ext_wdata = ext_wdata_q;
    assign bus.ext_we    = ext_we_q;
    assign gpio_out      = io_q[0];
    assign bus_err       = err_q;
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Self-checking bench for cpu_mem_ctrl: directed steps plus random
// accesses checked against an address-range reference model.
module tb_cpu_mem_ctrl;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       bus_err;

    cpu_mem_ctrl_if bus ();

    cpu_mem_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  ram_m [int];
    logic [7:0]  io_m [16];
    logic        err_m;
    logic [7:0]  gpio_m;
    logic [15:0] pool [8];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // 0 unmapped, 1 RAM, 2 IO, 3 external
    function automatic int region_of(input logic [15:0] a);
        if (a >= 16'hD000 && a <= 16'hD00F) return 2;
        if (a >= 16'hE000) return 3;
        if (a < 16'h2000) return 1;
        return 0;
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        int off;
        off = int'(a[3:0]);
        case (region_of(a))
            1: return ram_m[int'(a[12:0])];
            2: begin
                if (off == 1) return gpio_m;
                if (off == 2) return {7'b0, err_m};
                return io_m[off];
            end
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
        int off;
        off = int'(a[3:0]);
        if (region_of(a) == 1)
            ram_m[int'(a[12:0])] = d;
        else if (region_of(a) == 2) begin
            if (off == 2) begin
                if (d[0]) err_m = 1'b0;
            end else if (off != 1)
                io_m[off] = d;
        end
    endtask

    task automatic acc(input logic [15:0] a, input logic [7:0] d,
                       input logic w);
        logic [7:0] exp;
        exp = model_rd(a);
        bus.ab = a;
        bus.we = w;
        bus.cpu_do = d;
        step;
        chk("acc_rdy", 16'(bus.rdy), 16'h1);
        if (!w)
            chk($sformatf("rd_%h", a), 16'(bus.cpu_di), 16'(exp));
        else
            model_wr(a, d);
        bus.we = 1'b0;
        bus.ab = 16'hC000;
    endtask

    task automatic ext(input logic [15:0] a, input logic [7:0] d,
                       input logic w, input int ack_at,
                       input logic [7:0] rd);
        int   k;
        logic acked;
        acked = (ack_at >= 1 && ack_at <= TIMEOUT);
        k = acked ? ack_at : TIMEOUT;
        bus.ab = a;
        bus.we = w;
        bus.cpu_do = d;
        step;
        // scribble a RAM write while waiting: must be ignored
        bus.ab = pool[$urandom_range(0, 7)];
        bus.we = 1'b1;
        bus.cpu_do = 8'($urandom);
        for (int i = 1; i <= k; i++) begin
            chk("wait_rdy", 16'(bus.rdy), 16'h0);
            chk("wait_req", 16'(bus.ext_req), 16'h1);
            chk("ext_addr", 16'(bus.ext_addr), 16'(a[12:0]));
            chk("ext_we", 16'(bus.ext_we), 16'(w));
            if (w) chk("ext_wdata", 16'(bus.ext_wdata), 16'(d));
            if (i == ack_at) begin
                bus.ext_ack = 1'b1;
                bus.ext_rdata = rd;
            end
            step;
            bus.ext_ack = 1'b0;
            bus.ext_rdata = 8'($urandom);
        end
        bus.we = 1'b0;
        bus.ab = 16'hC000;
        if (!acked) err_m = 1'b1;
        chk("done_rdy", 16'(bus.rdy), 16'h1);
        chk("done_req", 16'(bus.ext_req), 16'h0);
        if (!w)
            chk("ext_rd", 16'(bus.cpu_di), acked ? 16'(rd) : 16'h00FF);
        chk("bus_err", 16'(bus_err), 16'(err_m));
    endtask

    initial begin
        reset = 1'b1;
        gpio_in = 8'h00;
        bus.ab = 16'hC000;
        bus.we = 1'b0;
        bus.cpu_do = 8'h00;
        bus.ext_ack = 1'b0;
        bus.ext_rdata = 8'h00;
        for (int i = 0; i < 16; i++) io_m[i] = 8'h00;
        err_m = 1'b0;
        gpio_m = 8'h00;
        step;
        step;
        reset = 1'b0;

        chk("rst_rdy", 16'(bus.rdy), 16'h1);
        chk("rst_req", 16'(bus.ext_req), 16'h0);
        chk("rst_ext_we", 16'(bus.ext_we), 16'h0);
        chk("rst_ext_addr", 16'(bus.ext_addr), 16'h0);
        chk("rst_ext_wdata", 16'(bus.ext_wdata), 16'h0);
        chk("rst_bus_err", 16'(bus_err), 16'h0);
        chk("rst_gpio_out", 16'(gpio_out), 16'h0);
        chk("rst_cpu_di", 16'(bus.cpu_di), 16'h00FF);
        acc(16'hD002, 8'h00, 1'b0);

        acc(16'h0123, 8'hA5, 1'b1);
        acc(16'h0123, 8'h00, 1'b0);

        acc(16'hD000, 8'h3C, 1'b1);
        chk("gpio_out", 16'(gpio_out), 16'h003C);
        gpio_in = 8'h81;
        gpio_m = 8'h81;
        step;
        step;
        step;
        acc(16'hD001, 8'h00, 1'b0);

        pool[0] = 16'h0123;
        for (int i = 1; i < 8; i++) begin
            pool[i] = 16'($urandom_range(0, 16'h1FFF));
            acc(pool[i], 8'($urandom), 1'b1);
        end

        ext(16'hE010, 8'h00, 1'b0, 3, 8'h5A);
        ext(16'hF000, 8'h77, 1'b1, 0, 8'h00);
        acc(16'hD002, 8'h00, 1'b0);
        acc(16'hD002, 8'h01, 1'b1);
        chk("err_clear", 16'(bus_err), 16'h0);

        acc(16'hC000, 8'h00, 1'b0);
        acc(16'hC000, 8'h55, 1'b1);
        acc(16'hD010, 8'h00, 1'b0);
        ext(16'hE123, 8'h00, 1'b0, TIMEOUT, 8'hC3);
        acc(16'h0123, 8'h00, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 3)
                acc(pool[$urandom_range(0, 7)], 8'($urandom),
                    1'($urandom_range(0, 1)));
            else if (kind <= 5)
                acc(16'hD000 | 16'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom_range(0, 1)));
            else if (kind == 6)
                acc(16'($urandom_range(16'h2000, 16'hCFFF)),
                    8'($urandom), 1'($urandom_range(0, 1)));
            else
                ext({3'b111, 13'($urandom)}, 8'($urandom),
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, TIMEOUT), 8'($urandom));
        end

        bus.ab = 16'hE200;
        bus.we = 1'b0;
        step;
        bus.ab = pool[1];
        bus.we = 1'b1;
        bus.cpu_do = 8'h99;
        for (int i = 1; i <= 4; i++) step;
        chk("pre_rst_rdy", 16'(bus.rdy), 16'h0);
        bus.we = 1'b0;
        bus.ab = 16'hC000;
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) io_m[i] = 8'h00;
        err_m = 1'b0;
        chk("mid_rst_rdy", 16'(bus.rdy), 16'h1);
        chk("mid_rst_req", 16'(bus.ext_req), 16'h0);
        chk("mid_rst_gpio", 16'(gpio_out), 16'h0);
        chk("mid_rst_err", 16'(bus_err), 16'h0);
        chk("mid_rst_di", 16'(bus.cpu_di), 16'h00FF);
        bus.ext_ack = 1'b1;
        bus.ext_rdata = 8'h12;
        step;
        bus.ext_ack = 1'b0;
        chk("late_ack_rdy", 16'(bus.rdy), 16'h1);
        chk("late_ack_req", 16'(bus.ext_req), 16'h0);
        chk("late_ack_err", 16'(bus_err), 16'h0);
        acc(16'h0123, 8'h00, 1'b0);
        acc(pool[1], 8'h00, 1'b0);
        acc(16'hD000, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
